mem_stage: RTL

- Memory-access stage of the 5-stage pipeline.
- Consumes the E→M register outputs and drives a variable-latency data-memory bus with a req/ack handshake.
- Stalls the upstream pipeline while an access is outstanding, then loads the M→W pipeline register.
- Also retires syscalls (print/halt) from the M stage.

---
 rtl/mem_pkg.sv | 20 ++
 rtl/mem_stage_store_format.sv | 24 ++
 rtl/mem_stage.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the memory-access stage: FSM state encoding,
// syscall codes and byte-enable constants.
package mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [31:0] SYS_PRINT_INT = 32'd1;
    localparam logic [31:0] SYS_EXIT      = 32'd10;
    localparam logic [3:0]  BE_WORD       = 4'b1111;

    // Single-byte lane enable selected by the low address bits
    function automatic logic [3:0] byte_lane(input logic [1:0] addr_lo);
        return 4'b0001 << addr_lo;
    endfunction

endpackage

// File: rtl/mem_stage_store_format.sv
// store_format: combinational store-lane formatter. Word accesses (loads and
// store-word) use all four lanes; store-byte replicates the low data byte
// across the word and enables only the addressed lane.
module store_format
    import mem_pkg::*;
(
    input  logic [1:0]  i_addr_lo,
    input  logic        i_sb,
    input  logic [31:0] i_wdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata
);

    // Select lane enables and data replication for byte vs word stores
    always_comb begin
        o_be    = BE_WORD;
        o_wdata = i_wdata;
        if (i_sb) begin
            o_be    = byte_lane(i_addr_lo);
            o_wdata = {4{i_wdata[7:0]}};
        end
    end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: M stage of the 5-stage pipeline. Issues data-memory accesses on
// a req/ack bus, stalls upstream while an access is outstanding, loads the
// M->W register and retires print/halt syscalls.
// Optional build macro MEM_ALIGN_CHECK_EN: misaligned word accesses are
// dropped (no request, no stall, W bubble) and flagged on sticky align_err.
module mem_stage
    import mem_pkg::*;
#(
    parameter int unsigned TIMEOUT = 256,
    parameter int unsigned CNT_W   = 9
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        RegWriteM,
    input  logic        MemtoRegM,
    input  logic        MemWriteM,
    input  logic        MemWriteSBM,
    input  logic [31:0] ALUOutM,
    input  logic [31:0] WriteDataM,
    input  logic [4:0]  WriteRegM,
    input  logic [31:0] PCPlus4M,
    input  logic        JalM,
    input  logic        sysM,
    input  logic [31:0] regvM,
    input  logic [31:0] regaM,
    output logic        StallM,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        RegWriteW,
    output logic        MemtoRegW,
    output logic        JalW,
    output logic [31:0] ReadDataW,
    output logic [31:0] ALUOutW,
    output logic [31:0] PCPlus4W,
    output logic [4:0]  WriteRegW,
    output logic        sys_valid,
    output logic [31:0] sys_code,
    output logic [31:0] sys_arg,
    output logic        halt,
`ifdef MEM_ALIGN_CHECK_EN
    output logic        align_err,
`endif
    output logic        bus_err
);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [31:0]      r_rdata;

    logic             w_memop;
    logic             w_misalign;
    logic             w_issue;
    logic             w_timeout;
    logic [3:0]       w_be;
    logic [31:0]      w_wdata;

    assign w_memop = MemtoRegM | MemWriteM | MemWriteSBM;

`ifdef MEM_ALIGN_CHECK_EN
    assign w_misalign = ~halt & (MemtoRegM | MemWriteM) & (|ALUOutM[1:0]);
`else
    assign w_misalign = 1'b0;
`endif

    // A halted core or a rejected misaligned access never reaches the bus
    assign w_issue   = w_memop & ~halt & ~w_misalign;
    assign w_timeout = (r_cnt == CNT_W'(TIMEOUT - 1));
    assign StallM    = ((r_state == ST_IDLE) & w_issue) | (r_state == ST_BUSY);

    store_format u_store_format (
        .i_addr_lo (ALUOutM[1:0]),
        .i_sb      (MemWriteSBM),
        .i_wdata   (WriteDataM),
        .o_be      (w_be),
        .o_wdata   (w_wdata)
    );

    // Access FSM: register bus fields on issue, hold them while BUSY, capture read data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_rdata   <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= '0;
            bus_err   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_issue) begin
                        r_state   <= ST_BUSY;
                        r_cnt     <= '0;
                        mem_req   <= 1'b1;
                        mem_we    <= MemWriteM | MemWriteSBM;
                        mem_addr  <= {ALUOutM[31:2], 2'b00};
                        mem_wdata <= w_wdata;
                        mem_be    <= w_be;
                    end
                end
                ST_BUSY: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (mem_ack) begin
                        r_state <= ST_DONE;
                        r_rdata <= mem_rdata;
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                    end else if (w_timeout) begin
                        r_state <= ST_DONE;
                        r_rdata <= '0;
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        bus_err <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // M->W pipeline register: bubble while stalled, otherwise load the M-stage instruction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            RegWriteW <= 1'b0;
            MemtoRegW <= 1'b0;
            JalW      <= 1'b0;
            ReadDataW <= '0;
            ALUOutW   <= '0;
            PCPlus4W  <= '0;
            WriteRegW <= '0;
        end else if (StallM) begin
            RegWriteW <= 1'b0;
        end else begin
            RegWriteW <= RegWriteM & ~halt & ~w_misalign;
            MemtoRegW <= MemtoRegM;
            JalW      <= JalM;
            ReadDataW <= r_rdata;
            ALUOutW   <= ALUOutM;
            PCPlus4W  <= PCPlus4M;
            WriteRegW <= WriteRegM;
        end
    end

    // Syscall retirement: one-cycle pulse when the stage advances; exit code sets sticky halt
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sys_valid <= 1'b0;
            sys_code  <= '0;
            sys_arg   <= '0;
            halt      <= 1'b0;
        end else begin
            sys_valid <= 1'b0;
            if (!StallM && sysM && !halt) begin
                sys_valid <= 1'b1;
                sys_code  <= regvM;
                sys_arg   <= regaM;
                if (regvM == SYS_EXIT) begin
                    halt <= 1'b1;
                end
            end
        end
    end

`ifdef MEM_ALIGN_CHECK_EN
    // Sticky flag for word accesses rejected because of a misaligned address
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            align_err <= 1'b0;
        end else if (!StallM && w_misalign) begin
            align_err <= 1'b1;
        end
    end
`endif

endmodule
